// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the fetch/step sequencer: instruction type codes, major opcodes
// (opcode[6:2]) and run-state encodings.
package instr_sequencer_pkg;

    localparam int unsigned TW = 3;

    localparam logic [2:0] TYPE_ILL = 3'd0;
    localparam logic [2:0] TYPE_R   = 3'd1;
    localparam logic [2:0] TYPE_I   = 3'd2;
    localparam logic [2:0] TYPE_S   = 3'd3;
    localparam logic [2:0] TYPE_B   = 3'd4;
    localparam logic [2:0] TYPE_U   = 3'd5;
    localparam logic [2:0] TYPE_J   = 3'd6;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_ALUI   = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ALU    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StHalted = 1'b1
    } seq_state_e;

    // Only 32-bit encodings (low bits 11) are decodable by this core.
    function automatic logic is_full_width(input logic [1:0] low_bits);
        return low_bits == 2'b11;
    endfunction

endpackage

// File: rtl/instr_sequencer_classifier.sv
// Purely combinational instruction-format classifier; shared with the trace/disassembly
// monitor so both agree on how an instruction word is typed.
module instr_type_classifier
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] ir,
    output logic [2:0]      instr_type
);

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[XLEN-1:7];

    always_comb begin
        instr_type = TYPE_ILL;
        if (is_full_width(ir[1:0])) begin
            case (ir[6:2])
                OP_ALU:                                        instr_type = TYPE_R;
                OP_ALUI, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: instr_type = TYPE_I;
                OP_STORE:                                      instr_type = TYPE_S;
                OP_BRANCH:                                     instr_type = TYPE_B;
                OP_LUI, OP_AUIPC:                              instr_type = TYPE_U;
                OP_JAL:                                        instr_type = TYPE_J;
                default:                                       instr_type = TYPE_ILL;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/step sequencer: owns IR, T-step counter, run/halt state and retired count, and
// closes the loop on the decoder's ir_we / T_rst / hlt outputs.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned MAX_T = 3,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] mem_data,
    input  logic            mem_busy,
    input  logic            ir_we,
    input  logic            T_rst,
    input  logic            hlt,
    input  logic            resume,
    output logic [XLEN-1:0] instr_out,
    output logic [TW-1:0]   T_out,
    output logic [2:0]      instr_type,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            run,
    output logic            retire,
    output logic [XLEN-1:0] instret,
    output logic            seq_fault
);

    localparam logic [TW-1:0]   TMax    = TW'(MAX_T);
    localparam logic [XLEN-1:0] CntOne  = {{(XLEN-1){1'b0}}, 1'b1};

    seq_state_e      state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic            retire_q, retire_d;
    logic            fault_q, fault_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            t_q       <= '0;
            ir_q      <= '0;
            instret_q <= '0;
            retire_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            retire_q  <= retire_d;
            fault_q   <= fault_d;
        end
    end

    // mem_busy freezes everything, including a pending resume.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        retire_d  = 1'b0;
        fault_d   = fault_q;
        if (!mem_busy) begin
            case (state_q)
                StRun: begin
                    if (ir_we) begin
                        ir_d = mem_data;
                    end
                    if (T_rst) begin
                        t_d       = '0;
                        retire_d  = 1'b1;
                        instret_d = instret_q + CntOne;
                        if (hlt) begin
                            state_d = StHalted;
                        end
                    end else if (t_q == TMax) begin
                        t_d     = '0;
                        fault_d = 1'b1;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
                StHalted: begin
                    t_d = '0;
                    if (resume) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                    t_d     = '0;
                end
            endcase
        end
    end

    instr_type_classifier #(
        .XLEN (XLEN)
    ) u_classifier (
        .ir         (ir_q),
        .instr_type (instr_type)
    );

    assign instr_out = ir_q;
    assign T_out     = t_q;
    assign run       = (state_q == StRun);
    assign retire    = retire_q;
    assign instret   = instret_q;
    assign seq_fault = fault_q;
    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign rd        = ir_q[11:7];
    assign rs1       = ir_q[19:15];
    assign rs2       = ir_q[24:20];

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized traffic
// against a behavioural model of the sequencer.
module tb_instr_sequencer;

    localparam int MAX_T = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_data;
    logic        mem_busy, ir_we, T_rst, hlt, resume;
    logic [31:0] instr_out, instret;
    logic [2:0]  T_out, instr_type, funct3;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic        run, retire, seq_fault;

    instr_sequencer #(
        .MAX_T (MAX_T),
        .XLEN  (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_data   (mem_data),
        .mem_busy   (mem_busy),
        .ir_we      (ir_we),
        .T_rst      (T_rst),
        .hlt        (hlt),
        .resume     (resume),
        .instr_out  (instr_out),
        .T_out      (T_out),
        .instr_type (instr_type),
        .opcode     (opcode),
        .funct3     (funct3),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .run        (run),
        .retire     (retire),
        .instret    (instret),
        .seq_fault  (seq_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Behavioural model state
    bit          m_halted;
    int          m_t;
    logic [31:0] m_ir;
    logic [31:0] m_cnt;
    bit          m_fault;
    bit          m_retire;

    typedef struct {
        logic [4:0] opc;
        int         ty;
    } op_entry_t;
    op_entry_t op_table[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_type(input logic [31:0] w);
        if (w[1:0] != 2'b11) return 0;
        foreach (op_table[i]) begin
            if (op_table[i].opc == w[6:2]) return op_table[i].ty;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_halted = 0;
        m_t      = 0;
        m_ir     = '0;
        m_cnt    = '0;
        m_fault  = 0;
        m_retire = 0;
    endtask

    task automatic drive(input bit b, input bit we, input logic [31:0] d, input bit tr,
                         input bit h, input bit rs);
        mem_busy = b;
        ir_we    = we;
        mem_data = d;
        T_rst    = tr;
        hlt      = h;
        resume   = rs;
    endtask

    // One clock edge: apply the sequencing rules to the model, then sample the DUT.
    task automatic step();
        @(posedge clk);
        m_retire = 0;
        if (!mem_busy) begin
            if (m_halted) begin
                m_t = 0;
                if (resume) m_halted = 0;
            end else begin
                if (ir_we) m_ir = mem_data;
                if (T_rst) begin
                    m_t      = 0;
                    m_retire = 1;
                    m_cnt    = m_cnt + 1;
                    if (hlt) m_halted = 1;
                end else if (m_t == MAX_T) begin
                    m_t     = 0;
                    m_fault = 1;
                end else begin
                    m_t = m_t + 1;
                end
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".T"}, {29'd0, T_out}, m_t);
        check({tag, ".ir"}, instr_out, m_ir);
        check({tag, ".run"}, {31'd0, run}, {31'd0, !m_halted});
        check({tag, ".retire"}, {31'd0, retire}, {31'd0, m_retire});
        check({tag, ".instret"}, instret, m_cnt);
        check({tag, ".fault"}, {31'd0, seq_fault}, {31'd0, m_fault});
        check({tag, ".type"}, {29'd0, instr_type}, ref_type(m_ir));
        check({tag, ".rd"}, {27'd0, rd}, {27'd0, m_ir[11:7]});
        check({tag, ".rs1"}, {27'd0, rs1}, {27'd0, m_ir[19:15]});
        check({tag, ".rs2"}, {27'd0, rs2}, {27'd0, m_ir[24:20]});
        check({tag, ".f3"}, {29'd0, funct3}, {29'd0, m_ir[14:12]});
        check({tag, ".opc"}, {25'd0, opcode}, {25'd0, m_ir[6:0]});
    endtask

    logic [31:0] sweep_w[6];
    int          sweep_t[6];

    initial begin
        n_vec = 0;
        n_err = 0;
        op_table = '{'{5'b01100, 1}, '{5'b00100, 2}, '{5'b00000, 2}, '{5'b11001, 2},
                     '{5'b00011, 2}, '{5'b11100, 2}, '{5'b01000, 3}, '{5'b11000, 4},
                     '{5'b01101, 5}, '{5'b00101, 5}, '{5'b11011, 6}};
        sweep_w = '{32'h0000006F, 32'h00000063, 32'h00000037, 32'h00000023,
                    32'h00000000, 32'hFFFFFFFF};
        sweep_t = '{6, 4, 5, 3, 0, 0};

        drive(0, 0, '0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("rst.T", {29'd0, T_out}, 0);
        check("rst.ir", instr_out, 0);
        check("rst.run", {31'd0, run}, 1);
        check("rst.instret", instret, 0);
        check("rst.fault", {31'd0, seq_fault}, 0);
        check("rst.retire", {31'd0, retire}, 0);
        rst_n = 1'b1;

        // Fetch ADDI x1, x0, 5
        drive(0, 1, 32'h00500093, 0, 0, 0);
        step();
        check("addi.T", {29'd0, T_out}, 1);
        check("addi.ir", instr_out, 32'h00500093);
        check("addi.type", {29'd0, instr_type}, 2);
        check("addi.rd", {27'd0, rd}, 1);
        check("addi.rs1", {27'd0, rs1}, 0);
        check("addi.f3", {29'd0, funct3}, 0);
        drive(0, 0, '0, 1, 0, 0);
        step();
        check("addi_ret.T", {29'd0, T_out}, 0);
        check("addi_ret.retire", {31'd0, retire}, 1);
        check("addi_ret.instret", instret, 1);

        // Memory stall during fetch
        drive(1, 1, 32'h00000023, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.T", {29'd0, T_out}, 0);
            check("stall.ir", instr_out, 32'h00500093);
            check("stall.retire", {31'd0, retire}, 0);
        end
        mem_busy = 0;
        step();
        check("stall_go.T", {29'd0, T_out}, 1);
        check("stall_go.ir", instr_out, 32'h00000023);
        check("stall_go.type", {29'd0, instr_type}, 3);

        // Halt / resume
        drive(0, 0, '0, 1, 1, 0);
        step();
        check("halt.run", {31'd0, run}, 0);
        check("halt.T", {29'd0, T_out}, 0);
        check("halt.instret", instret, 2);
        drive(0, 1, 32'hDEADBEEF, 1, 1, 0);
        step();
        check("halted.ir", instr_out, 32'h00000023);
        check("halted.instret", instret, 2);
        check("halted.run", {31'd0, run}, 0);
        drive(0, 0, '0, 0, 0, 1);
        step();
        check("resume.run", {31'd0, run}, 1);
        check("resume.T", {29'd0, T_out}, 0);

        // Watchdog: no T_rst
        drive(0, 0, '0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("wdog.T", {29'd0, T_out}, i % 4);
            check("wdog.fault", {31'd0, seq_fault}, (i == 4) ? 1 : 0);
            check("wdog.instret", instret, 2);
        end
        step();
        check("wdog_sticky.fault", {31'd0, seq_fault}, 1);

        // Classification sweep
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, sweep_w[i], 0, 0, 0);
            step();
            check("sweep.type", {29'd0, instr_type}, sweep_t[i]);
            drive(0, 0, '0, 1, 0, 0);
            step();
        end
        check_all("post_sweep");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(3) == 0), $urandom_range(1), $urandom(),
                  ($urandom_range(2) == 0), ($urandom_range(5) == 0),
                  ($urandom_range(3) == 0));
            step();
            check_all("rand");
        end

        // Reset mid-instruction at T=2
        begin
            bit reached;
            reached = 0;
            for (int i = 0; i < 20 && !reached; i++) begin
                if (!m_halted && m_t == 2) reached = 1;
                else begin
                    drive(0, 0, '0, 0, 0, m_halted);
                    step();
                end
            end
            check("midrst.reachT2", {31'd0, reached}, 1);
        end
        drive(0, 1, 32'h12345678, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst.T", {29'd0, T_out}, 0);
        check("midrst.ir", instr_out, 0);
        check("midrst.instret", instret, 0);
        check("midrst.fault", {31'd0, seq_fault}, 0);
        check("midrst.run", {31'd0, run}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_all("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/step sequencer directly upstream of `InstructionDecoder` in the multicycle RV32 core. It owns the instruction register, the T-step counter and the run/halt state. It also classifies the latched instruction into the format `type` and field signals that the decoder consumes. It closes the loop on the decoder's `ir_we`, `T_rst` and `hlt` outputs, stalls on memory busy, and counts retired instructions.

## Interface
Clock is `clk`; reset `rst_n` is asynchronous, active-low.

Parameters:
- `MAX_T`, default 3: highest legal T step; reaching it without `T_rst` is a sequencing fault.
- `XLEN`, default 32: instruction and `instret` width.

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  async active-low reset
- `mem_data`  in  32  memory read data bus (instruction word during fetch)
- `mem_busy`  in  1  memory not ready this cycle; freezes the sequencer
- `ir_we`  in  1  from decoder: latch `mem_data` into IR
- `T_rst`  in  1  from decoder: instruction complete, return T to 0
- `hlt`  in  1  from decoder: enter HALTED
- `resume`  in  1  leave HALTED (level or pulse)
- `instr_out`  out  32  instruction register
- `T_out`  out  3  current step, to decoder `T_in`
- `type`  out  3  0 illegal, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J
- `opcode`  out  7  IR[6:0]
- `funct3`  out  3  IR[14:12]
- `rd`, `rs1`, `rs2`  out  5 each  IR[11:7], IR[19:15], IR[24:20]
- `run`  out  1  high in RUN; datapath gates all register/PC/memory writes with it
- `retire`  out  1  one-cycle pulse per completed instruction
- `instret`  out  32  retired-instruction count
- `seq_fault`  out  1  sticky; set on watchdog timeout

## Operation
- State machine: RUN, HALTED.
  - Reset: RUN, T=0, IR=0, instret=0, retire=0, seq_fault=0.
- Advance condition in RUN: `adv = !mem_busy`. When `adv` is low, T, IR, instret and state all hold, and `retire` is 0.
- In RUN with `adv` high, on the clock edge:
  - `ir_we` set: IR <= `mem_data`.
  - `T_rst` set: T <= 0, `retire` pulses, instret <= instret+1 (wraps at 2^32).
  - `T_rst` and `hlt` both set: state <= HALTED. The halting instruction does count as retired.
  - `T_rst` clear and T == MAX_T: T <= 0, seq_fault <= 1, no retire.
  - Otherwise: T <= T+1.
- HALTED:
  - T is forced to 0 and `run` is 0.
  - `ir_we`, `T_rst` and `hlt` are ignored; IR and instret are frozen.
  - `resume` set: state <= RUN next edge, and fetch begins at T=0.
- `resume` while in RUN: no effect. `hlt` without `T_rst`: ignored (the decoder always pairs them).
- Classification (combinational, from IR):
  - IR[1:0] != 2'b11 gives type 0.
  - Otherwise by IR[6:2]:
    - 01100 gives R.
    - 00100, 00000, 11001, 00011, 11100 give I.
    - 01000 gives S.
    - 11000 gives B.
    - 01101, 00101 give U.
    - 11011 gives J.
    - Any other value gives 0.
- `seq_fault` clears only on reset.

## Timing
- All state changes on the rising edge of `clk`; outputs are registered except `type` and the fields, which are combinational from the registered IR.
- Fetch to decode: IR valid and `type` valid in the cycle T=1, one edge after the T=0 cycle in which `ir_we` was accepted.
- `retire` is high for exactly the cycle after the accepting edge, coincident with T=0.
- `mem_busy` has priority over every other input. A stalled T=0 fetch re-presents `ir_we` each cycle until accepted.
- HALTED to RUN latency is 1 edge. `run` is low in the first cycle after the halting edge.
- Reset mid-instruction: asynchronous return to reset values; no partial retire is counted.

## Structure
- Shared constants header (alongside the decoder's constants header) holds:
  - type codes TYPE_ILL..TYPE_J;
  - opcode[6:2] major-opcode constants (OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_BRANCH, OP_FENCE, OP_SYSTEM);
  - state encodings.
- One sub-module, `instr_type_classifier`: purely combinational, IR in, `type` out. It is reused by the trace/disassembly monitor.

## Test plan
- Fetch ADDI: at T=0, `mem_data`=0x00500093, `ir_we`=1, `mem_busy`=0 -> next cycle T=1, `instr_out`=0x00500093, type=2, rd=1, rs1=0, funct3=0. Then `T_rst`=1 -> T=0, `retire` pulse, instret=1.
- Memory stall: `mem_busy`=1 for 3 cycles during T=0 with `ir_we`=1 -> T stays 0 and IR is unchanged. On the 4th cycle (`mem_busy`=0) IR latches and T=1.
- Halt/resume: at T=1, `hlt`=`T_rst`=1 -> HALTED, run=0, T=0, instret incremented once. `ir_we`=1 with `mem_data`=0xDEADBEEF leaves IR unchanged. `resume`=1 -> run=1 next cycle.
- Watchdog: MAX_T=3, no `T_rst` -> T goes 0,1,2,3,0, seq_fault=1 and stays set, instret unchanged.
- Classification sweep: 0x0000006F -> 6; 0x00000063 -> 4; 0x00000037 -> 5; 0x00000023 -> 3; 0x00000000 -> 0; 0xFFFFFFFF -> 0.
- Reset mid-op: drop `rst_n` at T=2 with instret=5 -> immediately T=0, IR=0, instret=0, seq_fault=0, run=1.
